// File: rtl/bn_pkg.sv
// Shared constants for the range batch-normalization stages.
// Holds the default sample width, FSM state codes and signed-extreme helpers.
package bn_pkg;

  localparam int BN_DATA_WIDTH = 16;

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  // Extremes of a w-bit signed number, returned sign-extended to 32 bits (w <= 32).
  function automatic logic signed [31:0] smax(input int w);
    return 32'sh7FFF_FFFF >>> (32 - w);
  endfunction

  function automatic logic signed [31:0] smin(input int w);
    return 32'sh8000_0000 >>> (32 - w);
  endfunction

endpackage

// File: rtl/bn_minmax_upd.sv
// Combinational signed max/min update of one sample against the running extremes.
// Zero latency; no flow control of its own.
module bn_minmax_upd #(
  parameter int DATA_WIDTH = 16
) (
  input  logic signed [DATA_WIDTH-1:0] sample,
  input  logic signed [DATA_WIDTH-1:0] cur_max,
  input  logic signed [DATA_WIDTH-1:0] cur_min,
  output logic signed [DATA_WIDTH-1:0] nxt_max,
  output logic signed [DATA_WIDTH-1:0] nxt_min
);

  assign nxt_max = (sample > cur_max) ? sample : cur_max;
  assign nxt_min = (sample < cur_min) ? sample : cur_min;

endmodule

// File: rtl/bn_range_stat.sv
// Batch mean/range accumulator: one result per 2**BATCH_LOG2 samples, valid 1 cycle after the last one.
// Input stalls (in_ready=0) while a result waits for out_ready; one bubble cycle per batch.
module bn_range_stat
  import bn_pkg::*;
#(
  parameter int DATA_WIDTH = BN_DATA_WIDTH,
  parameter int BATCH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_mean,
  output logic [DATA_WIDTH:0]   out_range
);

  localparam int SUM_W = DATA_WIDTH + BATCH_LOG2;

  localparam logic signed [31:0] SMAX32 = smax(DATA_WIDTH);
  localparam logic signed [31:0] SMIN32 = smin(DATA_WIDTH);
  localparam logic signed [DATA_WIDTH-1:0] VMAX = SMAX32[DATA_WIDTH-1:0];
  localparam logic signed [DATA_WIDTH-1:0] VMIN = SMIN32[DATA_WIDTH-1:0];

  logic [0:0]                   state;
  logic [BATCH_LOG2-1:0]        count;
  logic signed [SUM_W-1:0]      sum;
  logic signed [SUM_W-1:0]      sum_nxt;
  logic signed [DATA_WIDTH-1:0] cur_max;
  logic signed [DATA_WIDTH-1:0] cur_min;
  logic signed [DATA_WIDTH-1:0] nxt_max;
  logic signed [DATA_WIDTH-1:0] nxt_min;
  logic [DATA_WIDTH:0]          range_nxt;
  logic                         xfer;
  logic                         last;

  // Handshake outputs come straight from state, so out_ready never reaches in_ready.
  assign in_ready  = (state == ST_ACCUM);
  assign out_valid = (state == ST_HOLD);

  assign xfer = in_valid & in_ready;
  assign last = (count == {BATCH_LOG2{1'b1}});

  assign sum_nxt = sum + $signed({{BATCH_LOG2{in_data[DATA_WIDTH-1]}}, in_data});

  bn_minmax_upd #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_minmax (
    .sample  ($signed(in_data)),
    .cur_max (cur_max),
    .cur_min (cur_min),
    .nxt_max (nxt_max),
    .nxt_min (nxt_min)
  );

  // One extra bit so a full-scale spread (max - min) cannot wrap.
  assign range_nxt = {nxt_max[DATA_WIDTH-1], nxt_max} - {nxt_min[DATA_WIDTH-1], nxt_min};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_ACCUM;
      count     <= '0;
      sum       <= '0;
      cur_max   <= VMIN;
      cur_min   <= VMAX;
      out_mean  <= '0;
      out_range <= '0;
    end else if (clear) begin
      state   <= ST_ACCUM;
      count   <= '0;
      sum     <= '0;
      cur_max <= VMIN;
      cur_min <= VMAX;
    end else begin
      case (state)
        ST_ACCUM: begin
          if (xfer) begin
            sum     <= sum_nxt;
            cur_max <= nxt_max;
            cur_min <= nxt_min;
            count   <= count + 1'b1;
            if (last) begin
              // Floor mean is the upper DATA_WIDTH bits of the updated sum.
              out_mean  <= sum_nxt[SUM_W-1:BATCH_LOG2];
              out_range <= range_nxt;
              state     <= ST_HOLD;
            end
          end
        end
        default: begin
          if (out_ready) begin
            state   <= ST_ACCUM;
            count   <= '0;
            sum     <= '0;
            cur_max <= VMIN;
            cur_min <= VMAX;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bn_range_stat.sv
// Self-checking bench for bn_range_stat: directed scenarios then randomized traffic
// against a queue-based batch model.
module tb_bn_range_stat;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_mean;
  logic [16:0] out_range;

  int checks;
  int failures;

  // Reference model: accepted samples of the open batch, hold flag, last result.
  int          q[$];
  bit          holding;
  logic [15:0] exp_mean;
  logic [16:0] exp_range;

  bn_range_stat #(
    .DATA_WIDTH (16),
    .BATCH_LOG2 (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mean  (out_mean),
    .out_range (out_range)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    holding   = 1'b0;
    exp_mean  = '0;
    exp_range = '0;
  endtask

  // What the next rising edge should do, given the inputs now being driven.
  task automatic model_edge();
    int s, mx, mn;
    if (clear) begin
      q.delete();
      holding = 1'b0;
    end else if (!holding) begin
      if (in_valid) begin
        q.push_back(int'($signed(in_data)));
        if (q.size() == 8) begin
          s  = 0;
          mx = q[0];
          mn = q[0];
          foreach (q[i]) begin
            s += q[i];
            if (q[i] > mx) mx = q[i];
            if (q[i] < mn) mn = q[i];
          end
          exp_mean  = 16'(s >>> 3);
          exp_range = 17'(mx - mn);
          holding   = 1'b1;
          q.delete();
        end
      end
    end else if (out_ready) begin
      holding = 1'b0;
    end
  endtask

  task automatic check_all();
    chk("in_ready",  32'(in_ready),  32'(!holding));
    chk("out_valid", 32'(out_valid), 32'(holding));
    chk("out_mean",  32'(out_mean),  32'(exp_mean));
    chk("out_range", 32'(out_range), 32'(exp_range));
  endtask

  // Called at a falling edge: check, drive, predict, advance one cycle.
  task automatic step(input bit v, input logic [15:0] d, input bit ordy, input bit clr);
    check_all();
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    clear     = clr;
    model_edge();
    @(negedge clk);
  endtask

  task automatic expect_result(input string tag, input logic [15:0] m, input logic [16:0] r);
    chk({tag, "_vld"},   32'(out_valid), 32'd1);
    chk({tag, "_rdy"},   32'(in_ready),  32'd0);
    chk({tag, "_mean"},  32'(out_mean),  32'(m));
    chk({tag, "_range"}, 32'(out_range), 32'(r));
  endtask

  task automatic consume();
    step(1'b0, 16'h0, 1'b1, 1'b0);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Ramp 1..8: mean 36>>>3 = 4, range 7, result one cycle after the 8th sample.
    for (int i = 1; i <= 8; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
    expect_result("ramp", 16'd4, 17'd7);
    step(1'b1, 16'd99, 1'b0, 1'b0);
    chk("ramp_hold_rdy", 32'(in_ready), 32'd0);
    consume();

    // Negative constants and floor rounding.
    for (int i = 0; i < 8; i++) step(1'b1, 16'hFFFD, 1'b0, 1'b0);
    expect_result("neg3", 16'hFFFD, 17'd0);
    consume();
    for (int i = 0; i < 8; i++) step(1'b1, 16'hFFFF, 1'b0, 1'b0);
    expect_result("neg1", 16'hFFFF, 17'd0);
    consume();
    for (int i = 0; i < 7; i++) step(1'b1, 16'hFFFF, 1'b0, 1'b0);
    step(1'b1, 16'hFFFE, 1'b0, 1'b0);
    expect_result("floor", 16'hFFFE, 17'd1);
    consume();

    // Full-scale alternation: sum -4, mean -1, range 65535 without wrap.
    for (int i = 0; i < 8; i++) step(1'b1, (i % 2 == 0) ? 16'h8000 : 16'h7FFF, 1'b0, 1'b0);
    expect_result("ext", 16'hFFFF, 17'd65535);

    // Backpressure with upstream still offering data.
    for (int i = 0; i < 5; i++) step(1'b1, 16'd10, 1'b0, 1'b0);
    expect_result("bp", 16'hFFFF, 17'd65535);
    step(1'b1, 16'd10, 1'b1, 1'b0);
    chk("bp_bubble_vld", 32'(out_valid), 32'd0);
    for (int i = 0; i < 8; i++) step(1'b1, 16'd10, 1'b0, 1'b0);
    expect_result("bp_next", 16'd10, 17'd0);
    consume();

    // Clear mid-batch drops the partial batch and the same-cycle sample.
    for (int i = 0; i < 3; i++) step(1'b1, 16'd100, 1'b0, 1'b0);
    step(1'b1, 16'd100, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 16'd10, 1'b0, 1'b0);
    expect_result("clr", 16'd10, 17'd0);
    step(1'b0, 16'h0, 1'b0, 1'b1);
    chk("clr_hold_vld", 32'(out_valid), 32'd0);
    chk("clr_hold_mean", 32'(out_mean), 32'd10);

    // Asynchronous reset after 5 samples, checked before the next rising edge.
    for (int i = 0; i < 5; i++) step(1'b1, 16'd500, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_rdy",   32'(in_ready),  32'd1);
    chk("arst_vld",   32'(out_valid), 32'd0);
    chk("arst_mean",  32'(out_mean),  32'd0);
    chk("arst_range", 32'(out_range), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
    expect_result("post_rst", 16'd3, 17'd7);
    consume();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      int          r;
      logic [15:0] d;
      r = $urandom_range(0, 9);
      if (r == 0)      d = 16'h8000;
      else if (r == 1) d = 16'h7FFF;
      else if (r == 2) d = 16'($urandom_range(0, 15));
      else             d = 16'($urandom);
      step($urandom_range(0, 3) != 0, d, $urandom_range(0, 2) != 0, $urandom_range(0, 63) == 0);
    end
    check_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
